// File: rtl/apb_slave_mux_wdog.sv
// APB segment fan-out: decodes one master onto up to 16 slaves and merges the
// responses, with a wait-state watchdog that aborts transfers to stalled slaves.
module apb_slave_mux_wdog #(
    parameter int unsigned NUM_PORTS       = 16,
    parameter logic [15:0] PORT_EN         = 16'hFFFF,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter bit          ERR_ON_UNMAPPED = 1'b1
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [3:0]                  DECODE4BIT,
    input  logic                        PSEL,
    input  logic                        PENABLE,
    output logic [NUM_PORTS-1:0]        PSELx,
    input  logic [NUM_PORTS-1:0]        PREADYx,
    input  logic [NUM_PORTS*DATA_W-1:0] PRDATAx,
    input  logic [NUM_PORTS-1:0]        PSLVERRx,
    output logic                        PREADY,
    output logic [DATA_W-1:0]           PRDATA,
    output logic                        PSLVERR,
    output logic                        TIMEOUT_EVT,
    output logic [3:0]                  TIMEOUT_ID,
    output logic                        TIMEOUT_FLAG,
    input  logic                        TIMEOUT_CLR
);

    localparam int unsigned CNT_W   = 16;
    localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_MAX = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         acc_id;
    logic [15:0]        map_pad, rdy_pad, err_pad, sel_onehot;
    logic [DATA_W-1:0]  port_data [16];
    logic               sel_mapped, sel_ready, sel_err;
    logic [DATA_W-1:0]  sel_data;
    logic               wait_expired;

    // Pad per-port inputs to a full 16-entry table so the 4-bit decode indexes it directly
    for (genvar g = 0; g < 16; g++) begin : g_pad
        if (g < NUM_PORTS) begin : g_real
            assign port_data[g] = PRDATAx[g*DATA_W +: DATA_W];
            assign rdy_pad[g]   = PREADYx[g];
            assign err_pad[g]   = PSLVERRx[g];
            assign map_pad[g]   = PORT_EN[g];
        end else begin : g_absent
            assign port_data[g] = '0;
            assign rdy_pad[g]   = 1'b0;
            assign err_pad[g]   = 1'b0;
            assign map_pad[g]   = 1'b0;
        end
    end

    assign sel_mapped   = map_pad[DECODE4BIT];
    assign sel_ready    = rdy_pad[DECODE4BIT];
    assign sel_err      = err_pad[DECODE4BIT];
    assign sel_data     = port_data[DECODE4BIT];
    assign sel_onehot   = 16'd1 << DECODE4BIT;
    assign wait_expired = ({1'b0, cnt} + 17'd1) >= 17'(CNT_MAX);

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: a decode change mid-wait is a protocol violation and simply drops the transfer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (WDOG_EN && PSEL && PENABLE && sel_mapped && !sel_ready)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!PSEL || (DECODE4BIT != acc_id) || sel_ready) state_nxt = IDLE;
                else if (wait_expired)                            state_nxt = ABORT;
            end
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter, transfer id and sticky abort status
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt          <= '0;
            acc_id       <= '0;
            TIMEOUT_ID   <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            if (state_nxt == IDLE)
                cnt <= '0;
            else if (state == ACCESS && !sel_ready && cnt < CNT_W'(CNT_MAX))
                cnt <= cnt + CNT_W'(1);

            if (state == IDLE && state_nxt == ACCESS) acc_id <= DECODE4BIT;
            if (state == ACCESS && state_nxt == ABORT) TIMEOUT_ID <= DECODE4BIT;

            // Set wins over clear for the whole abort window
            if (state_nxt == ABORT || state == ABORT) TIMEOUT_FLAG <= 1'b1;
            else if (TIMEOUT_CLR)                     TIMEOUT_FLAG <= 1'b0;
        end
    end

    // Merged response and per-port selects
    always_comb begin
        PSELx       = '0;
        PREADY      = 1'b1;
        PRDATA      = '0;
        PSLVERR     = 1'b0;
        TIMEOUT_EVT = 1'b0;
        if (WDOG_EN && state == ABORT) begin
            PSLVERR     = 1'b1;
            TIMEOUT_EVT = 1'b1;
        end else if (PSEL) begin
            if (sel_mapped) begin
                PSELx   = sel_onehot[NUM_PORTS-1:0];
                PREADY  = sel_ready;
                PRDATA  = sel_data;
                PSLVERR = sel_err;
            end else begin
                PSLVERR = ERR_ON_UNMAPPED & PENABLE;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mux_wdog.sv
// Bench for apb_slave_mux_wdog: directed scenarios plus randomized traffic
// checked against an access-cycle-counting reference model.
module tb_apb_slave_mux_wdog;

    localparam int unsigned DW = 32;
    localparam int unsigned TA = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] dec;
    logic psel, pen, clr;
    logic [15:0] rdy, err;
    logic [DW-1:0] rdata [16];
    logic [16*DW-1:0] prdata_in;

    logic [7:0]    psel_a;
    logic          pready_a, pslverr_a, evt_a, flag_a;
    logic [DW-1:0] prdata_a;
    logic [3:0]    id_a;
    logic [15:0]   psel_b;
    logic          pready_b, pslverr_b, evt_b, flag_b;
    logic [DW-1:0] prdata_b;
    logic [3:0]    id_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign prdata_in[g*DW +: DW] = rdata[g];
    end

    apb_slave_mux_wdog #(.NUM_PORTS(8), .PORT_EN(16'hFFFF), .DATA_W(DW),
                         .TIMEOUT_CYCLES(TA), .ERR_ON_UNMAPPED(1'b1)) u_a (
        .PCLK(clk), .PRESETn(rst_n), .DECODE4BIT(dec), .PSEL(psel), .PENABLE(pen),
        .PSELx(psel_a), .PREADYx(rdy[7:0]), .PRDATAx(prdata_in[8*DW-1:0]),
        .PSLVERRx(err[7:0]), .PREADY(pready_a), .PRDATA(prdata_a), .PSLVERR(pslverr_a),
        .TIMEOUT_EVT(evt_a), .TIMEOUT_ID(id_a), .TIMEOUT_FLAG(flag_a), .TIMEOUT_CLR(clr));

    apb_slave_mux_wdog #(.NUM_PORTS(16), .PORT_EN(16'hFFFB), .DATA_W(DW),
                         .TIMEOUT_CYCLES(0), .ERR_ON_UNMAPPED(1'b0)) u_b (
        .PCLK(clk), .PRESETn(rst_n), .DECODE4BIT(dec), .PSEL(psel), .PENABLE(pen),
        .PSELx(psel_b), .PREADYx(rdy), .PRDATAx(prdata_in),
        .PSLVERRx(err), .PREADY(pready_b), .PRDATA(prdata_b), .PSLVERR(pslverr_b),
        .TIMEOUT_EVT(evt_b), .TIMEOUT_ID(id_b), .TIMEOUT_FLAG(flag_b), .TIMEOUT_CLR(clr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        psel = 1'b0; pen = 1'b0; clr = 1'b0; dec = 4'd0; rdy = '0; err = '0;
        for (int i = 0; i < 16; i++) rdata[i] = 32'h1111_0000 + 32'(i);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        psel = 1'b0; pen = 1'b0; clr = 1'b0; dec = 4'd0; rdy = '0; err = '0;
        for (int i = 0; i < 16; i++) rdata[i] = 32'h1111_0000 + 32'(i);
        @(negedge clk);
        n_chk++; if (evt_a !== 1'b0) $display("FAIL reset_evt got %b want 0", evt_a); else n_pass++;
        n_chk++; if (flag_a !== 1'b0) $display("FAIL reset_flag got %b want 0", flag_a); else n_pass++;
        n_chk++; if (id_a !== 4'd0) $display("FAIL reset_id got %0d want 0", id_a); else n_pass++;
        n_chk++; if (pready_a !== 1'b1) $display("FAIL reset_pready got %b want 1", pready_a); else n_pass++;
        n_chk++; if (psel_b !== 16'h0) $display("FAIL reset_psel_b got %h want 0", psel_b); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wait_read();
        apply_reset();
        dec = 4'd3; psel = 1'b1; pen = 1'b0; rdata[3] = 32'hA5A5_0003;
        @(negedge clk);
        n_chk++; if (psel_a !== 8'h08) $display("FAIL wr_setup_psel got %h want 08", psel_a); else n_pass++;
        tick();
        pen = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_chk++; if (pready_a !== 1'b0) $display("FAIL wr_wait%0d_pready got %b want 0", c, pready_a); else n_pass++;
            tick();
        end
        rdy[3] = 1'b1;
        @(negedge clk);
        n_chk++; if (pready_a !== 1'b1) $display("FAIL wr_done_pready got %b want 1", pready_a); else n_pass++;
        n_chk++; if (prdata_a !== 32'hA5A5_0003) $display("FAIL wr_done_prdata got %h want a5a50003", prdata_a); else n_pass++;
        n_chk++; if (pslverr_a !== 1'b0) $display("FAIL wr_done_pslverr got %b want 0", pslverr_a); else n_pass++;
        n_chk++; if (evt_a !== 1'b0) $display("FAIL wr_done_evt got %b want 0", evt_a); else n_pass++;
        tick();
        psel = 1'b0; pen = 1'b0; rdy = '0;
        @(negedge clk);
        n_chk++; if (flag_a !== 1'b0) $display("FAIL wr_after_flag got %b want 0", flag_a); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        apply_reset();
        dec = 4'd5; psel = 1'b1; pen = 1'b0; rdata[5] = 32'hDEAD_0005;
        tick();
        pen = 1'b1;
        for (int c = 1; c <= int'(TA); c++) begin
            @(negedge clk);
            n_chk++; if (pready_a !== 1'b0) $display("FAIL to_c%0d_pready got %b want 0", c, pready_a); else n_pass++;
            n_chk++; if (evt_a !== 1'b0) $display("FAIL to_c%0d_evt got %b want 0", c, evt_a); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_chk++; if (pready_a !== 1'b1) $display("FAIL to_abort_pready got %b want 1", pready_a); else n_pass++;
        n_chk++; if (pslverr_a !== 1'b1) $display("FAIL to_abort_pslverr got %b want 1", pslverr_a); else n_pass++;
        n_chk++; if (prdata_a !== 32'h0) $display("FAIL to_abort_prdata got %h want 0", prdata_a); else n_pass++;
        n_chk++; if (psel_a !== 8'h00) $display("FAIL to_abort_psel got %h want 00", psel_a); else n_pass++;
        n_chk++; if (evt_a !== 1'b1) $display("FAIL to_abort_evt got %b want 1", evt_a); else n_pass++;
        n_chk++; if (id_a !== 4'd5) $display("FAIL to_abort_id got %0d want 5", id_a); else n_pass++;
        n_chk++; if (flag_a !== 1'b1) $display("FAIL to_abort_flag got %b want 1", flag_a); else n_pass++;
        tick();
        psel = 1'b0; pen = 1'b0;
        @(negedge clk);
        n_chk++; if (evt_a !== 1'b0) $display("FAIL to_after_evt got %b want 0", evt_a); else n_pass++;
        n_chk++; if (flag_a !== 1'b1) $display("FAIL to_after_flag got %b want 1", flag_a); else n_pass++;
        tick();
    endtask

    task automatic test_clr_collision();
        apply_reset();
        dec = 4'd6; psel = 1'b1; pen = 1'b0;
        tick();
        pen = 1'b1;
        for (int c = 1; c <= int'(TA); c++) tick();
        clr = 1'b1;
        @(negedge clk);
        n_chk++; if (evt_a !== 1'b1) $display("FAIL clr_abort_evt got %b want 1", evt_a); else n_pass++;
        tick();
        clr = 1'b0; psel = 1'b0; pen = 1'b0;
        @(negedge clk);
        n_chk++; if (flag_a !== 1'b1) $display("FAIL clr_collide_flag got %b want 1", flag_a); else n_pass++;
        n_chk++; if (id_a !== 4'd6) $display("FAIL clr_collide_id got %0d want 6", id_a); else n_pass++;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        @(negedge clk);
        n_chk++; if (flag_a !== 1'b0) $display("FAIL clr_cleared_flag got %b want 0", flag_a); else n_pass++;
        n_chk++; if (id_a !== 4'd6) $display("FAIL clr_sticky_id got %0d want 6", id_a); else n_pass++;
        tick();
    endtask

    task automatic test_unmapped();
        apply_reset();
        for (int i = 0; i < 16; i++) rdata[i] = 32'hCAFE_0000 + 32'(i);
        dec = 4'd12; psel = 1'b1; pen = 1'b0;
        @(negedge clk);
        n_chk++; if (pslverr_a !== 1'b0) $display("FAIL um_setup_pslverr got %b want 0", pslverr_a); else n_pass++;
        tick();
        pen = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_chk++; if (pready_a !== 1'b1) $display("FAIL um_c%0d_pready got %b want 1", c, pready_a); else n_pass++;
            n_chk++; if (pslverr_a !== 1'b1) $display("FAIL um_c%0d_pslverr got %b want 1", c, pslverr_a); else n_pass++;
            n_chk++; if (psel_a !== 8'h00) $display("FAIL um_c%0d_psel got %h want 00", c, psel_a); else n_pass++;
            n_chk++; if (prdata_a !== 32'h0) $display("FAIL um_c%0d_prdata got %h want 0", c, prdata_a); else n_pass++;
            n_chk++; if (evt_a !== 1'b0) $display("FAIL um_c%0d_evt got %b want 0", c, evt_a); else n_pass++;
            tick();
        end
        dec = 4'd2;
        @(negedge clk);
        n_chk++; if (pready_b !== 1'b1) $display("FAIL dis_pready got %b want 1", pready_b); else n_pass++;
        n_chk++; if (pslverr_b !== 1'b0) $display("FAIL dis_pslverr got %b want 0", pslverr_b); else n_pass++;
        n_chk++; if (psel_b !== 16'h0) $display("FAIL dis_psel got %h want 0", psel_b); else n_pass++;
        n_chk++; if (prdata_b !== 32'h0) $display("FAIL dis_prdata got %h want 0", prdata_b); else n_pass++;
        tick();
    endtask

    task automatic test_no_watchdog();
        apply_reset();
        dec = 4'd11; psel = 1'b1; pen = 1'b1; rdata[11] = 32'h0B0B_000B; err[11] = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c % 50 == 1) begin
                n_chk++; if (pready_b !== 1'b0) $display("FAIL nw_c%0d_pready got %b want 0", c, pready_b); else n_pass++;
                n_chk++; if (psel_b !== 16'h0800) $display("FAIL nw_c%0d_psel got %h want 0800", c, psel_b); else n_pass++;
            end
            n_chk++; if (evt_b !== 1'b0) $display("FAIL nw_c%0d_evt got %b want 0", c, evt_b); else n_pass++;
            tick();
        end
        rdy[11] = 1'b1;
        @(negedge clk);
        n_chk++; if (pready_b !== 1'b1) $display("FAIL nw_done_pready got %b want 1", pready_b); else n_pass++;
        n_chk++; if (prdata_b !== 32'h0B0B_000B) $display("FAIL nw_done_prdata got %h want 0b0b000b", prdata_b); else n_pass++;
        n_chk++; if (pslverr_b !== 1'b1) $display("FAIL nw_done_pslverr got %b want 1", pslverr_b); else n_pass++;
        n_chk++; if (flag_b !== 1'b0) $display("FAIL nw_flag got %b want 0", flag_b); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        dec = 4'd1; psel = 1'b1; pen = 1'b0;
        tick();
        pen = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (evt_a !== 1'b0) $display("FAIL rma_r%0d_evt got %b want 0", c, evt_a); else n_pass++;
            n_chk++; if (flag_a !== 1'b0) $display("FAIL rma_r%0d_flag got %b want 0", c, flag_a); else n_pass++;
            n_chk++; if (pready_a !== 1'b0) $display("FAIL rma_r%0d_pready got %b want 0", c, pready_a); else n_pass++;
            tick();
        end
        psel = 1'b0; pen = 1'b0; rst_n = 1'b1;
        tick();
        psel = 1'b1;
        tick();
        pen = 1'b1;
        for (int c = 1; c <= int'(TA) + 1; c++) begin
            @(negedge clk);
            n_chk++;
            if (evt_a !== (c == int'(TA) + 1)) $display("FAIL rma_fresh_c%0d_evt got %b want %b", c, evt_a, c == int'(TA) + 1);
            else n_pass++;
            tick();
        end
        psel = 1'b0; pen = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int k;
        logic [3:0] kid, mid;
        logic mflag, ab, map_a, map_b, act_a, act_b;
        logic [7:0] e_psel_a;
        logic [15:0] e_psel_b;
        apply_reset();
        k = 0; kid = 4'd0; mid = 4'd0; mflag = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) dec = 4'($urandom_range(0, 15));
            psel = ($urandom_range(0, 7) != 0);
            pen  = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            rdy  = 16'($urandom & $urandom & $urandom);
            err  = 16'($urandom);
            for (int i = 0; i < 16; i++) rdata[i] = $urandom;
            @(negedge clk);
            // A stall is numbered by access cycle; cycle TA+1 is the abort cycle
            ab    = (k == int'(TA) + 1);
            map_a = (dec < 4'd8);
            map_b = (dec != 4'd2);
            act_a = !ab && psel && map_a;
            act_b = psel && map_b;
            e_psel_a = act_a ? 8'(16'd1 << dec) : 8'h00;
            e_psel_b = act_b ? (16'd1 << dec) : 16'h0000;
            n_chk++; if (psel_a !== e_psel_a) $display("FAIL rnd%0d_psel_a got %h want %h", n, psel_a, e_psel_a); else n_pass++;
            n_chk++; if (pready_a !== (ab ? 1'b1 : act_a ? rdy[dec] : 1'b1)) $display("FAIL rnd%0d_pready_a got %b", n, pready_a); else n_pass++;
            n_chk++; if (prdata_a !== (act_a ? rdata[dec] : 32'h0)) $display("FAIL rnd%0d_prdata_a got %h", n, prdata_a); else n_pass++;
            n_chk++;
            if (pslverr_a !== (ab ? 1'b1 : !psel ? 1'b0 : map_a ? err[dec] : pen)) $display("FAIL rnd%0d_pslverr_a got %b", n, pslverr_a);
            else n_pass++;
            n_chk++; if (evt_a !== ab) $display("FAIL rnd%0d_evt_a got %b want %b", n, evt_a, ab); else n_pass++;
            n_chk++; if (flag_a !== mflag) $display("FAIL rnd%0d_flag_a got %b want %b", n, flag_a, mflag); else n_pass++;
            n_chk++; if (id_a !== mid) $display("FAIL rnd%0d_id_a got %0d want %0d", n, id_a, mid); else n_pass++;
            n_chk++; if (psel_b !== e_psel_b) $display("FAIL rnd%0d_psel_b got %h want %h", n, psel_b, e_psel_b); else n_pass++;
            n_chk++; if (pready_b !== (act_b ? rdy[dec] : 1'b1)) $display("FAIL rnd%0d_pready_b got %b", n, pready_b); else n_pass++;
            n_chk++; if (prdata_b !== (act_b ? rdata[dec] : 32'h0)) $display("FAIL rnd%0d_prdata_b got %h", n, prdata_b); else n_pass++;
            n_chk++; if (pslverr_b !== (act_b ? err[dec] : 1'b0)) $display("FAIL rnd%0d_pslverr_b got %b", n, pslverr_b); else n_pass++;
            n_chk++; if (evt_b !== 1'b0 || flag_b !== 1'b0) $display("FAIL rnd%0d_wdog_b got %b%b want 00", n, evt_b, flag_b); else n_pass++;
            if (ab) k = 0;
            else if (k == 0) begin
                if (psel && pen && map_a && !rdy[dec]) begin
                    k = 2;
                    kid = dec;
                end
            end else if (!psel || dec != kid || rdy[dec]) k = 0;
            else k++;
            if (k == int'(TA) + 1) mid = kid;
            if (k == int'(TA) + 1 || ab) mflag = 1'b1;
            else if (clr) mflag = 1'b0;
            tick();
        end
        psel = 1'b0; pen = 1'b0; clr = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        #2;
        test_reset();
        test_wait_read();
        test_timeout();
        test_clr_collision();
        test_unmapped();
        test_no_watchdog();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
